// File: rtl/cp0_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_if
//  Description : Pipeline <-> coprocessor-0 signal bundle.
//                master : pipeline side (drives exception info, mfc0/mtc0
//                         controls, interrupt lines; receives RD/EPC/IntReq)
//                slave  : cp0_unit side
//  Signals     : PC, BD, ExcOccur, ExcCode, HWInt    exception/interrupt inputs
//                A1, A2, WD, WE, EXLClr              mfc0/mtc0/eret controls
//                RD, EPCOut, IntReq                  results back to pipeline
//  Revision    : 1.0 - initial release
// ============================================================================
interface cp0_if;
    logic [31:0] PC;
    logic        BD;
    logic        ExcOccur;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] WD;
    logic        WE;
    logic        EXLClr;
    logic [31:0] RD;
    logic [31:0] EPCOut;
    logic        IntReq;

    modport master (
        output PC, BD, ExcOccur, ExcCode, HWInt, A1, A2, WD, WE, EXLClr,
        input  RD, EPCOut, IntReq
    );

    modport slave (
        input  PC, BD, ExcOccur, ExcCode, HWInt, A1, A2, WD, WE, EXLClr,
        output RD, EPCOut, IntReq
    );
endinterface
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_unit
//  Description : Coprocessor-0 exception/interrupt controller at the M/W
//                boundary. Holds SR, Cause, EPC, PRId and a Count/Compare
//                timer; raises IntReq combinationally when an enabled
//                interrupt or a synchronous exception must be taken.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - cp0_if.slave (exception info, mfc0/mtc0/eret,
//                         RD / EPCOut / IntReq results)
//  Parameters  : PRID   - constant returned by PRId (register 15)
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h0000_4D49
) (
    input  wire   clk,
    input  wire   rst_n,
    cp0_if.slave  bus
);

    localparam logic [4:0] c_reg_count   = 5'd9;
    localparam logic [4:0] c_reg_compare = 5'd11;
    localparam logic [4:0] c_reg_sr      = 5'd12;
    localparam logic [4:0] c_reg_cause   = 5'd13;
    localparam logic [4:0] c_reg_epc     = 5'd14;
    localparam logic [4:0] c_reg_prid    = 5'd15;

    // Architectural state
    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;

    // Request logic
    logic [5:0]  w_int6;
    logic        w_int_pend;
    logic        w_exc_pend;
    logic        w_int_req;
    logic        w_mtc0;
    logic [31:0] w_epc_src;

    // Timer interrupt shares the top hardware line.
    assign w_int6     = {bus.HWInt[5] | r_timer_int, bus.HWInt[4:0]};
    assign w_int_pend = (|(w_int6 & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_pend = bus.ExcOccur & ~r_sr_exl;
    assign w_int_req  = w_int_pend | w_exc_pend;

    // An mtc0 issued in the same cycle as a taken exception is dropped.
    assign w_mtc0     = bus.WE & ~w_int_req;

    // Delay-slot exceptions restart at the branch, one word earlier.
    assign w_epc_src  = bus.BD ? (bus.PC - 32'd4) : bus.PC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_im     <= '0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
            r_count     <= '0;
            r_compare   <= '0;
            r_timer_int <= 1'b0;
        end else begin
            r_cause_ip <= w_int6;

            if (w_mtc0 && bus.A2 == c_reg_count) begin
                r_count <= bus.WD;
            end else begin
                r_count <= r_count + 32'd1;
            end

            if (w_mtc0 && bus.A2 == c_reg_compare) begin
                r_compare <= bus.WD;
            end

            // A Compare write acknowledges the timer; it wins over a match
            // on the same edge.
            if (w_mtc0 && bus.A2 == c_reg_compare) begin
                r_timer_int <= 1'b0;
            end else if (r_count == r_compare && r_compare != 32'd0) begin
                r_timer_int <= 1'b1;
            end

            if (w_int_req) begin
                r_sr_exl    <= 1'b1;
                r_cause_exc <= w_int_pend ? 5'd0 : bus.ExcCode;
                r_cause_bd  <= bus.BD;
                r_epc       <= {w_epc_src[31:2], 2'b00};
            end else begin
                if (w_mtc0 && bus.A2 == c_reg_sr) begin
                    r_sr_im  <= bus.WD[15:10];
                    r_sr_ie  <= bus.WD[0];
                    // eret in the same cycle still clears EXL
                    r_sr_exl <= bus.WD[1] & ~bus.EXLClr;
                end else if (bus.EXLClr) begin
                    r_sr_exl <= 1'b0;
                end

                if (w_mtc0 && bus.A2 == c_reg_epc) begin
                    r_epc <= {bus.WD[31:2], 2'b00};
                end
            end
        end
    end

    // mfc0 read mux
    always_comb begin
        bus.RD = 32'd0;
        case (bus.A1)
            c_reg_count:   bus.RD = r_count;
            c_reg_compare: bus.RD = r_compare;
            c_reg_sr:      bus.RD = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
            c_reg_cause:   bus.RD = {r_cause_bd, 15'd0, r_cause_ip, 3'd0,
                                     r_cause_exc, 2'b00};
            c_reg_epc:     bus.RD = r_epc;
            c_reg_prid:    bus.RD = PRID;
            default:       bus.RD = 32'd0;
        endcase
    end

    assign bus.EPCOut = r_epc;
    assign bus.IntReq = w_int_req;

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_unit
//  Description : Directed self-checking bench for cp0_unit. Inputs change
//                1 time unit after the rising edge; outputs are checked
//                before the next rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h0000_4D49;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    cp0_if bus ();

    cp0_unit #(.PRID(PRID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        bus.A1 = a;
        #1;
        chk(tag, bus.RD, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n        = 1'b0;
        bus.PC       = '0;
        bus.BD       = 1'b0;
        bus.ExcOccur = 1'b0;
        bus.ExcCode  = '0;
        bus.HWInt    = '0;
        bus.A1       = '0;
        bus.A2       = '0;
        bus.WD       = '0;
        bus.WE       = 1'b0;
        bus.EXLClr   = 1'b0;

        // ---------------- reset state ----------------
        #2;
        rd(5'd12, "rst_sr", 32'd0);
        rd(5'd15, "rst_prid", PRID);
        chk("rst_epcout", bus.EPCOut, 32'd0);
        chk("rst_intreq", {31'd0, bus.IntReq}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- overflow exception ----------------
        bus.ExcOccur = 1'b1;
        bus.ExcCode  = 5'd12;
        bus.PC       = 32'h0000_3010;
        bus.BD       = 1'b0;
        #1;
        chk("ov_intreq", {31'd0, bus.IntReq}, 32'd1);
        tick();
        chk("ov_epc", bus.EPCOut, 32'h0000_3010);
        rd(5'd13, "ov_cause", 32'h0000_0030);
        rd(5'd12, "ov_sr_exl", 32'h0000_0002);
        chk("ov_masked", {31'd0, bus.IntReq}, 32'd0);

        // ---------------- delay-slot exception ----------------
        bus.ExcOccur = 1'b0;
        bus.EXLClr   = 1'b1;
        tick();
        bus.EXLClr   = 1'b0;
        rd(5'd12, "eret_sr", 32'd0);
        bus.ExcOccur = 1'b1;
        bus.PC       = 32'h0000_3014;
        bus.BD       = 1'b1;
        tick();
        bus.ExcOccur = 1'b0;
        bus.BD       = 1'b0;
        chk("bd_epc", bus.EPCOut, 32'h0000_3010);
        rd(5'd13, "bd_cause", 32'h8000_0030);

        // ---------------- interrupt vs exception ----------------
        bus.WE = 1'b1;
        bus.A2 = 5'd12;
        bus.WD = 32'h0000_0401;
        tick();
        bus.WE = 1'b0;
        rd(5'd12, "im_sr", 32'h0000_0401);
        bus.HWInt    = 6'b000001;
        bus.ExcOccur = 1'b1;
        bus.ExcCode  = 5'd12;
        bus.PC       = 32'h0000_3020;
        #1;
        chk("int_intreq", {31'd0, bus.IntReq}, 32'd1);
        tick();
        bus.ExcOccur = 1'b0;
        rd(5'd13, "int_cause", 32'h0000_0400);
        chk("int_epc", bus.EPCOut, 32'h0000_3020);
        rd(5'd12, "int_sr", 32'h0000_0403);
        chk("int_masked", {31'd0, bus.IntReq}, 32'd0);
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        rd(5'd12, "int_eret_sr", 32'h0000_0401);
        chk("int_reassert", {31'd0, bus.IntReq}, 32'd1);
        bus.HWInt = 6'b000000;
        #1;
        chk("int_drop", {31'd0, bus.IntReq}, 32'd0);

        // ---------------- mtc0 / exception collision ----------------
        bus.ExcOccur = 1'b1;
        bus.ExcCode  = 5'd10;
        bus.PC       = 32'h0000_4000;
        bus.WE       = 1'b1;
        bus.A2       = 5'd14;
        bus.WD       = 32'h1234_5678;
        tick();
        bus.ExcOccur = 1'b0;
        bus.WE       = 1'b0;
        chk("col_epc", bus.EPCOut, 32'h0000_4000);
        rd(5'd13, "col_cause", 32'h0000_0028);
        bus.WE = 1'b1;
        bus.A2 = 5'd14;
        bus.WD = 32'h1234_567B;
        tick();
        bus.WE = 1'b0;
        chk("mtc0_epc", bus.EPCOut, 32'h1234_5678);

        // ---------------- timer ----------------
        bus.WE = 1'b1;
        bus.A2 = 5'd9;
        bus.WD = 32'd0;
        tick();                                   // E0: Count = 0
        rd(5'd9, "tmr_count0", 32'd0);
        bus.A2 = 5'd11;
        bus.WD = 32'd5;
        tick();                                   // E1: Compare = 5
        bus.A2 = 5'd12;
        bus.WD = 32'h0000_8001;
        tick();                                   // E2: SR = IM5|IE
        bus.WE = 1'b0;
        rd(5'd9, "tmr_count2", 32'd2);
        chk("tmr_e2", {31'd0, bus.IntReq}, 32'd0);
        tick();
        tick();
        tick();                                   // E5
        chk("tmr_e5", {31'd0, bus.IntReq}, 32'd0);
        tick();                                   // E6
        chk("tmr_e6", {31'd0, bus.IntReq}, 32'd1);
        tick();                                   // E7: interrupt taken
        rd(5'd13, "tmr_cause", 32'h0000_8000);
        bus.WE = 1'b1;
        bus.A2 = 5'd11;
        bus.WD = 32'd100;
        tick();                                   // E8: Compare = 100
        bus.WE     = 1'b0;
        bus.EXLClr = 1'b1;
        tick();                                   // E9
        bus.EXLClr = 1'b0;
        chk("tmr_cleared", {31'd0, bus.IntReq}, 32'd0);
        rd(5'd13, "tmr_cause_clr", 32'd0);

        // ---------------- reads ----------------
        rd(5'd15, "rd_prid", PRID);
        rd(5'd7,  "rd_unused", 32'd0);
        rd(5'd11, "rd_compare", 32'd100);
        rd(5'd9,  "rd_count9", 32'd9);
        tick();
        rd(5'd9,  "rd_count10", 32'd10);

        // ---------------- asynchronous reset mid-run ----------------
        #2;
        rst_n = 1'b0;
        rd(5'd12, "arst_sr", 32'd0);
        rd(5'd13, "arst_cause", 32'd0);
        rd(5'd14, "arst_epc", 32'd0);
        rd(5'd9,  "arst_count", 32'd0);
        rd(5'd11, "arst_compare", 32'd0);
        rd(5'd15, "arst_prid", PRID);
        chk("arst_epcout", bus.EPCOut, 32'd0);
        chk("arst_intreq", {31'd0, bus.IntReq}, 32'd0);
        tick();
        rst_n = 1'b1;
        rd(5'd9, "rel_count", 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
